// File: rtl/mext_iterative_unit.sv
// mext_iterative_unit: iterative RV M-extension mul/div; define MEXT_DIV_EN to build the divider.
// Latency: XLEN+2 cycles accept-to-flagM; 2 cycles for divide-by-zero and signed overflow.
// Backpressure: one operation in flight; ready low while busy, startE ignored unless ready.
module mext_iterative_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            startE,
  input  logic [4:0]      alu_opE,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  input  logic            kill,
  output logic            ready,
  output logic            flagM,
  output logic [XLEN-1:0] result_m,
  output logic            illegal_op
);

  localparam logic [4:0] OP_MUL    = 5'b01011;
  localparam logic [4:0] OP_MULH   = 5'b01100;
  localparam logic [4:0] OP_MULHSU = 5'b01101;
  localparam logic [4:0] OP_MULHU  = 5'b01110;
  localparam logic [4:0] OP_DIV    = 5'b01111;
  localparam logic [4:0] OP_DIVU   = 5'b10000;
  localparam logic [4:0] OP_REM    = 5'b10001;
  localparam logic [4:0] OP_REMU   = 5'b10010;
  localparam int         CW        = $clog2(XLEN);
  localparam logic [CW-1:0] LAST   = CW'(XLEN - 1);

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

  state_t            state, state_n;
  logic [4:0]        op_q;
  logic [CW-1:0]     cnt;
  logic [XLEN-1:0]   opa_q;
  logic              neg_res_q;
  logic [2*XLEN-1:0] acc;

  // Operand decode: opcode class, signedness and magnitudes of the incoming operands.
  logic            is_mul_op, is_div_op, accept;
  logic            sgn_a, sgn_b, a_neg, b_neg;
  logic [XLEN-1:0] mag_a, mag_b;

  assign is_mul_op = alu_opE inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
  assign is_div_op = alu_opE inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  assign accept    = (state == IDLE) && startE && !kill && (is_mul_op || is_div_op);
  assign sgn_a     = alu_opE inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  assign sgn_b     = alu_opE inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  assign a_neg     = sgn_a & SrcAE[XLEN-1];
  assign b_neg     = sgn_b & SrcBE[XLEN-1];
  assign mag_a     = a_neg ? -SrcAE : SrcAE;
  assign mag_b     = b_neg ? -SrcBE : SrcBE;

  // Shift-add step: acc = {partial product high, remaining multiplier bits}.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opa_q} : '0);
  assign mul_next = {mul_sum, acc[XLEN-1:1]};

`ifdef MEXT_DIV_EN
  logic [XLEN-1:0]   opb_q;
  logic              neg_rem_q;
  logic              div_zero, div_ovf;
  logic [XLEN:0]     div_trial;
  logic [2*XLEN-1:0] div_next;

  // Special cases bypass the iteration and are loaded as final values.
  assign div_zero  = (SrcBE == '0);
  assign div_ovf   = sgn_b && (SrcAE == {1'b1, {(XLEN-1){1'b0}}}) && (SrcBE == '1);

  // Restoring step: acc = {partial remainder, dividend bits shifting into quotient}.
  assign div_trial = {acc[2*XLEN-1:XLEN], acc[XLEN-1]} - {1'b0, opb_q};
  assign div_next  = div_trial[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                                     : {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
`endif

  // Sign correction and result selection, consumed in FIX.
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   fix_res;
  always_comb begin
    prod    = neg_res_q ? -acc : acc;
    fix_res = prod[XLEN-1:0];
    case (op_q)
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod[2*XLEN-1:XLEN];
`ifdef MEXT_DIV_EN
      OP_DIV, OP_DIVU: fix_res = neg_res_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      OP_REM, OP_REMU: fix_res = neg_rem_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
`endif
      default: ;
    endcase
  end

  // State register; reset dominates kill and start.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state and handshake outputs; flagM in DONE ignores kill since the result has retired.
  always_comb begin
    state_n = state;
    ready   = 1'b0;
    flagM   = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (accept) begin
          if (is_mul_op) state_n = MUL;
`ifdef MEXT_DIV_EN
          else if (div_zero || div_ovf) state_n = FIX;
          else state_n = DIV;
`endif
        end
      end
      MUL, DIV: begin
        if (kill)              state_n = IDLE;
        else if (cnt == LAST)  state_n = FIX;
      end
      FIX:     state_n = kill ? IDLE : DONE;
      DONE: begin
        flagM   = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, iterate, and retire the corrected result leaving FIX.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= '0;
      cnt        <= '0;
      opa_q      <= '0;
      neg_res_q  <= 1'b0;
      acc        <= '0;
      result_m   <= '0;
      illegal_op <= 1'b0;
`ifdef MEXT_DIV_EN
      opb_q      <= '0;
      neg_rem_q  <= 1'b0;
`endif
    end else begin
      illegal_op <= 1'b0;
      if (accept) begin
        op_q      <= alu_opE;
        cnt       <= '0;
        opa_q     <= mag_a;
        neg_res_q <= a_neg ^ b_neg;
        acc       <= {{XLEN{1'b0}}, mag_b};
`ifdef MEXT_DIV_EN
        opb_q     <= mag_b;
        neg_rem_q <= a_neg;
        if (is_div_op) begin
          acc <= {{XLEN{1'b0}}, mag_a};
          if (div_zero) begin
            acc       <= {SrcAE, {XLEN{1'b1}}};
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
          end else if (div_ovf) begin
            acc       <= {{XLEN{1'b0}}, SrcAE};
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
          end
        end
`else
        illegal_op <= is_div_op;
`endif
      end else if (state == MUL) begin
        acc <= mul_next;
        cnt <= cnt + 1'b1;
      end
`ifdef MEXT_DIV_EN
      else if (state == DIV) begin
        acc <= div_next;
        cnt <= cnt + 1'b1;
      end
`endif
      else if (state == FIX && !kill) begin
        result_m <= fix_res;
      end
    end
  end

endmodule
